// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Five-stage pipeline hazard controller. Computes data and mul/div
//            stalls and D/E forwarding selects, and times the mul/div unit.
//            Optional stall statistics counter: HAZARD_STALL_STAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_tuse_rs,
    input  logic [1:0]  D_tuse_rt,
    input  logic        D_md_use,
    input  logic [4:0]  E_rs,
    input  logic [4:0]  E_rt,
    input  logic [4:0]  E_dst,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_dst,
    input  logic [1:0]  M_tnew,
    input  logic [4:0]  W_dst,
    input  logic        E_md_start,
    input  logic        E_md_div,
    output logic        stall_F,
    output logic        stall_D,
    output logic        flush_E,
    output logic [1:0]  fwd_D_rs,
    output logic [1:0]  fwd_D_rt,
    output logic [1:0]  fwd_E_rs,
    output logic [1:0]  fwd_E_rt,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cnt
);

    localparam logic [3:0] c_MULT_LOAD = 4'(MULT_CYC);
    localparam logic [3:0] c_DIV_LOAD  = 4'(DIV_CYC);

    logic [3:0] r_cnt;
    logic       w_stall_rs;
    logic       w_stall_rt;
    logic       w_stall_md;
    logic       w_stall;

    function automatic logic data_stall(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_dst,
        input logic [1:0] e_tnew,
        input logic [4:0] m_dst,
        input logic [1:0] m_tnew
    );
        return (tuse != 2'd3) && (src != 5'd0) &&
               (((src == e_dst) && (e_tnew > tuse)) ||
                ((src == m_dst) && (m_tnew > tuse)));
    endfunction

    // A matching producer that is not ready yet shadows older stages.
    function automatic logic [1:0] fwd_d_sel(
        input logic [4:0] src,
        input logic [4:0] e_dst,
        input logic [1:0] e_tnew,
        input logic [4:0] m_dst,
        input logic [1:0] m_tnew,
        input logic [4:0] w_dst
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (src != 5'd0) begin
            if (src == e_dst)
                sel = (e_tnew == 2'd0) ? 2'd1 : 2'd0;
            else if (src == m_dst)
                sel = (m_tnew == 2'd0) ? 2'd2 : 2'd0;
            else if (src == w_dst)
                sel = 2'd3;
        end
        return sel;
    endfunction

    function automatic logic [1:0] fwd_e_sel(
        input logic [4:0] src,
        input logic [4:0] m_dst,
        input logic [1:0] m_tnew,
        input logic [4:0] w_dst
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (src != 5'd0) begin
            if (src == m_dst)
                sel = (m_tnew == 2'd0) ? 2'd2 : 2'd0;
            else if (src == w_dst)
                sel = 2'd3;
        end
        return sel;
    endfunction

    assign w_stall_rs = data_stall(D_rs, D_tuse_rs, E_dst, E_tnew, M_dst, M_tnew);
    assign w_stall_rt = data_stall(D_rt, D_tuse_rt, E_dst, E_tnew, M_dst, M_tnew);
    assign md_busy    = (r_cnt != 4'd0) | E_md_start;
    assign w_stall_md = D_md_use & md_busy;
    assign w_stall    = w_stall_rs | w_stall_rt | w_stall_md;

    assign stall_F = w_stall;
    assign stall_D = w_stall;
    assign flush_E = w_stall;

    assign fwd_D_rs = fwd_d_sel(D_rs, E_dst, E_tnew, M_dst, M_tnew, W_dst);
    assign fwd_D_rt = fwd_d_sel(D_rt, E_dst, E_tnew, M_dst, M_tnew, W_dst);
    assign fwd_E_rs = fwd_e_sel(E_rs, M_dst, M_tnew, W_dst);
    assign fwd_E_rt = fwd_e_sel(E_rt, M_dst, M_tnew, W_dst);

    // A start while busy reloads the counter and suppresses the done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= 4'd0;
            md_done <= 1'b0;
        end else begin
            md_done <= (r_cnt == 4'd1) && !E_md_start;
            if (E_md_start)
                r_cnt <= E_md_div ? c_DIV_LOAD : c_MULT_LOAD;
            else if (r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
        end
    end

`ifdef HAZARD_STALL_STAT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_stall_cnt <= 32'd0;
        else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Vector table plus mul/div and reset sequences for pipe_hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  D_rs, D_rt, E_rs, E_rt, E_dst, M_dst, W_dst;
    logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic        D_md_use, E_md_start, E_md_div;
    logic        stall_F, stall_D, flush_E, md_busy, md_done;
    logic [1:0]  fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt;
    logic [31:0] stall_cnt;

    pipe_hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
        .D_md_use(D_md_use), .E_rs(E_rs), .E_rt(E_rt), .E_dst(E_dst),
        .E_tnew(E_tnew), .M_dst(M_dst), .M_tnew(M_tnew), .W_dst(W_dst),
        .E_md_start(E_md_start), .E_md_div(E_md_div),
        .stall_F(stall_F), .stall_D(stall_D), .flush_E(flush_E),
        .fwd_D_rs(fwd_D_rs), .fwd_D_rt(fwd_D_rt), .fwd_E_rs(fwd_E_rs),
        .fwd_E_rt(fwd_E_rt), .md_busy(md_busy), .md_done(md_done),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] d_rs, d_rt, e_rs, e_rt, e_dst, m_dst, w_dst;
        logic [1:0] tu_rs, tu_rt, e_tnew, m_tnew;
        logic       md_use, start, div;
        logic       x_stall, x_busy, x_done;
        logic [1:0] x_fdrs, x_fdrt, x_fers, x_fert;
    } vec_t;

    typedef struct {
        string      name;
        logic       stall, busy, done;
        logic [1:0] fdrs, fdrt, fers, fert;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t tbl[14];
    vec_t v;

    function automatic vec_t idle();
        vec_t r;
        r.d_rs = 0; r.d_rt = 0; r.e_rs = 0; r.e_rt = 0;
        r.e_dst = 0; r.m_dst = 0; r.w_dst = 0;
        r.tu_rs = 3; r.tu_rt = 3; r.e_tnew = 0; r.m_tnew = 0;
        r.md_use = 0; r.start = 0; r.div = 0;
        r.x_stall = 0; r.x_busy = 0; r.x_done = 0;
        r.x_fdrs = 0; r.x_fdrt = 0; r.x_fers = 0; r.x_fert = 0;
        return r;
    endfunction

    function automatic vec_t mk(
        input logic [4:0] d_rs, input logic [1:0] tu_rs,
        input logic [4:0] d_rt, input logic [1:0] tu_rt,
        input logic [4:0] e_rs, input logic [4:0] e_rt,
        input logic [4:0] e_dst, input logic [1:0] e_tnew,
        input logic [4:0] m_dst, input logic [1:0] m_tnew,
        input logic [4:0] w_dst, input logic x_stall,
        input logic [1:0] x_fdrs, input logic [1:0] x_fdrt,
        input logic [1:0] x_fers, input logic [1:0] x_fert
    );
        vec_t r;
        r = idle();
        r.d_rs = d_rs; r.tu_rs = tu_rs; r.d_rt = d_rt; r.tu_rt = tu_rt;
        r.e_rs = e_rs; r.e_rt = e_rt; r.e_dst = e_dst; r.e_tnew = e_tnew;
        r.m_dst = m_dst; r.m_tnew = m_tnew; r.w_dst = w_dst;
        r.x_stall = x_stall; r.x_fdrs = x_fdrs; r.x_fdrt = x_fdrt;
        r.x_fers = x_fers; r.x_fert = x_fert;
        return r;
    endfunction

    task automatic apply(input vec_t a);
        D_rs = a.d_rs; D_rt = a.d_rt; D_tuse_rs = a.tu_rs; D_tuse_rt = a.tu_rt;
        E_rs = a.e_rs; E_rt = a.e_rt; E_dst = a.e_dst; E_tnew = a.e_tnew;
        M_dst = a.m_dst; M_tnew = a.m_tnew; W_dst = a.w_dst;
        D_md_use = a.md_use; E_md_start = a.start; E_md_div = a.div;
    endtask

    task automatic push_exp(input vec_t a, input string name);
        exp_t e;
        e.name = name; e.stall = a.x_stall; e.busy = a.x_busy; e.done = a.x_done;
        e.fdrs = a.x_fdrs; e.fdrt = a.x_fdrt; e.fers = a.x_fers; e.fert = a.x_fert;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        e = sb_q.pop_front();
        n_tests++;
        if (stall_F !== e.stall || stall_D !== e.stall || flush_E !== e.stall ||
            fwd_D_rs !== e.fdrs || fwd_D_rt !== e.fdrt || fwd_E_rs !== e.fers ||
            fwd_E_rt !== e.fert || md_busy !== e.busy || md_done !== e.done) begin
            n_fail++;
            $display("FAIL %s: got stFDE=%b%b%b fD=%0d/%0d fE=%0d/%0d busy=%b done=%b; exp st=%b fD=%0d/%0d fE=%0d/%0d busy=%b done=%b",
                     e.name, stall_F, stall_D, flush_E, fwd_D_rs, fwd_D_rt,
                     fwd_E_rs, fwd_E_rt, md_busy, md_done, e.stall, e.fdrs,
                     e.fdrt, e.fers, e.fert, e.busy, e.done);
        end
    endtask

    // Inputs change just after the falling edge; outputs sampled 1ns later.
    task automatic run_cycle(input vec_t a, input string name);
        @(negedge clk);
        apply(a);
        push_exp(a, name);
        #1;
        pop_check();
    endtask

    task automatic check_cnt(input logic [31:0] exp_v, input string name);
        n_tests++;
        if (stall_cnt !== exp_v) begin
            n_fail++;
            $display("FAIL %s: stall_cnt got %0d exp %0d", name, stall_cnt, exp_v);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        apply(idle());
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic md_seq(input logic div, input int n_busy, input string name);
        vec_t s;
        s = idle(); s.start = 1; s.div = div; s.md_use = 1;
        s.x_busy = 1; s.x_stall = 1;
        run_cycle(s, name);
        s.start = 0;
        for (int i = 0; i < n_busy; i++) run_cycle(s, name);
        s.x_busy = 0; s.x_stall = 0; s.x_done = 1;
        run_cycle(s, {name, "_done"});
        s.md_use = 0; s.x_done = 0;
        run_cycle(s, {name, "_after"});
    endtask

    logic [31:0] exp_stat;

    initial begin
        //        d_rs tu  d_rt tu  e_rs e_rt e_dst tn m_dst tn w_dst st fdrs fdrt fers fert
        tbl[0]  = mk(8, 0,  0, 3,  0,  0,  8, 2,   0, 0,  0,   1, 0, 0, 0, 0);
        tbl[1]  = mk(8, 0,  0, 3,  0,  0,  0, 0,   8, 1,  0,   1, 0, 0, 0, 0);
        tbl[2]  = mk(8, 0,  0, 3,  0,  0,  0, 0,   0, 0,  8,   0, 3, 0, 0, 0);
        tbl[3]  = mk(0, 3,  5, 1,  0,  0,  5, 1,   0, 0,  0,   0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 3,  5, 1,  0,  0,  0, 0,   5, 0,  0,   0, 0, 2, 0, 0);
        tbl[5]  = mk(0, 0,  0, 3,  0,  0,  0, 2,   0, 0,  0,   0, 0, 0, 0, 0);
        tbl[6]  = mk(31, 0, 0, 3,  0,  0, 31, 0,   0, 0,  0,   0, 1, 0, 0, 0);
        tbl[7]  = mk(4, 1,  4, 3,  0,  0,  4, 0,   4, 0,  4,   0, 1, 1, 0, 0);
        tbl[8]  = mk(6, 2,  0, 3,  0,  0,  0, 0,   6, 1,  6,   0, 0, 0, 0, 0);
        tbl[9]  = mk(7, 3,  0, 3,  0,  0,  7, 2,   0, 0,  0,   0, 0, 0, 0, 0);
        tbl[10] = mk(0, 3,  0, 3,  9, 10,  0, 0,   9, 0, 10,   0, 0, 0, 2, 3);
        tbl[11] = mk(0, 3,  0, 3, 11,  0,  0, 0,  11, 1, 11,   0, 0, 0, 0, 0);
        tbl[12] = mk(0, 3, 12, 1,  0,  0,  0, 0,  12, 2,  0,   1, 0, 0, 0, 0);
        tbl[13] = mk(0, 3, 13, 0,  0,  0, 13, 1,   0, 0,  0,   1, 0, 0, 0, 0);

        reset = 1'b0;
        apply(idle());
        repeat (2) @(negedge clk);
        push_exp(idle(), "reset_state");
        #1;
        pop_check();
        check_cnt(32'd0, "reset_cnt");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) run_cycle(tbl[i], $sformatf("vec%0d", i));

        md_seq(1'b1, 10, "div");
        md_seq(1'b0, 5, "mult");

        // Restart while busy: the reload must swallow the pending done pulse.
        v = idle(); v.start = 1; v.x_busy = 1;
        run_cycle(v, "rs_mult");
        v.start = 0;
        for (int i = 0; i < 4; i++) run_cycle(v, "rs_busy");
        v.start = 1; v.div = 1;
        run_cycle(v, "rs_div");
        v.start = 0; v.div = 0;
        for (int i = 0; i < 10; i++) run_cycle(v, "rs_nodone");
        v.x_busy = 0; v.x_done = 1;
        run_cycle(v, "rs_done");

        // Asynchronous reset in the middle of a divide.
        do_reset();
        v = idle(); v.start = 1; v.div = 1; v.x_busy = 1;
        run_cycle(v, "ar_start");
        v.start = 0; v.div = 0;
        run_cycle(v, "ar_t1");
        run_cycle(v, "ar_t2");
        @(negedge clk);
        apply(idle());
        #2 reset = 1'b0;
        #1;
        push_exp(idle(), "ar_async");
        pop_check();
        check_cnt(32'd0, "ar_cnt");
        v = idle(); v.start = 1; v.x_busy = 1;
        apply(v);
        push_exp(v, "ar_follow");
        #1;
        pop_check();
        apply(idle());
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 14; i++) run_cycle(idle(), "ar_nodone");

        // Stall statistics: three single-cycle load-use stalls plus a divide.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_cycle(tbl[0], "st_load");
            run_cycle(idle(), "st_idle");
        end
        md_seq(1'b1, 10, "st_div");
`ifdef HAZARD_STALL_STAT_EN
        exp_stat = 32'd14;
`else
        exp_stat = 32'd0;
`endif
        @(negedge clk);
        check_cnt(exp_stat, "stall_cnt");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the five-stage pipeline. Each cycle it decides whether the F2D and D2E pipeline registers advance, hold or clear, and selects forwarding sources for D-stage and E-stage operands. It also times the multi-cycle multiply/divide unit so HI/LO consumers wait until the result exists. All pipeline-register `pause`/clear inputs are driven from here.

## Interface

- `MULT_CYC`, 5: busy cycles after a multiply starts.
- `DIV_CYC`, 10: busy cycles after a divide starts.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `D_rs`, `D_rt`  in  5 each  D-stage source register numbers.
- `D_tuse_rs`, `D_tuse_rt`  in  2 each  cycles until the operand is needed; 3 = operand unused.
- `D_md_use`  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- `E_rs`, `E_rt`  in  5 each  E-stage source register numbers.
- `E_dst`  in  5  E-stage destination register; 0 = no write.
- `E_tnew`  in  2  cycles until the E result is produced.
- `M_dst`  in  5  M-stage destination register; 0 = no write.
- `M_tnew`  in  2  cycles until the M result is produced.
- `W_dst`  in  5  W-stage destination register; 0 = no write.
- `E_md_start`  in  1  mult/div issued in E this cycle.
- `E_md_div`  in  1  qualifies `E_md_start`: 1 = divide, 0 = multiply.
- `stall_F`  out  1  hold PC.
- `stall_D`  out  1  hold F2D.
- `flush_E`  out  1  clear D2E (bubble).
- `fwd_D_rs`, `fwd_D_rt`  out  2 each  0 = regfile, 1 = E, 2 = M, 3 = W.
- `fwd_E_rs`, `fwd_E_rt`  out  2 each  0 = D2E value, 2 = M, 3 = W.
- `md_busy`  out  1  multiply/divide unit busy.
- `md_done`  out  1  one-cycle pulse when busy ends.
- `stall_cnt`  out  32  stall-cycle count (see Configuration).

## Operation

- **Data stall, per operand X∈{rs,rt}.** Asserted when `tuse_X`≠3, `D_X`≠0, and either:
  - `D_X==E_dst` and `E_tnew > tuse_X`, or
  - `D_X==M_dst` and `M_tnew > tuse_X`.
- **MD stall.** `D_md_use && md_busy`.
- **Stall outputs.** `stall = data stall | MD stall`, and `stall_F = stall_D = flush_E = stall`. These are combinational.
- **D forwarding.** For an operand with `D_X≠0`, the first match in this order wins:
  - E, if `E_dst==D_X` and `E_tnew==0`;
  - M, if `M_dst==D_X` and `M_tnew==0`;
  - W, if `W_dst==D_X`;
  - otherwise 0.
  - A match with nonzero tnew blocks lower-priority sources. Select 0 is driven; the stall covers correctness.
- **E forwarding.** Same rule using M (tnew 0), then W. Register 0 always selects 0.
- **MD sequencer.** `cnt` is a 4-bit down-counter.
  - `E_md_start` loads `cnt` with `DIV_CYC` if divide, else `MULT_CYC`. This includes a start while already busy: the counter reloads and no `md_done` pulse is generated.
  - Otherwise, if `cnt≠0`, `cnt` decrements.
  - `md_busy = (cnt≠0) | E_md_start`.
  - `md_done` is registered: high for the one cycle after `cnt` goes 1→0.
  - Counting continues during pipeline stalls.
- Simultaneous data stall and MD stall produce a single stall; there is no double count.

## Timing

- Stall and forward outputs are combinational from the current-cycle inputs plus `cnt`. There is no added latency.
- A multiply started in cycle t holds `md_busy` high for cycles t through t+`MULT_CYC`. `md_done` is high in cycle t+`MULT_CYC`+1, and a D-stage mfhi is released that same cycle.
- Reset assertion, asynchronous and even mid-count:
  - `cnt=0`, `md_done=0`, `stall_cnt=0` immediately.
  - `md_busy` then follows `E_md_start` only.
  - Stall and forward outputs remain combinational from the inputs.
- Reset release: the first rising edge with `reset` high resumes normal operation.

## Configuration

- `HAZARD_STALL_STAT_EN`
  - Defined: `stall_cnt` increments on every rising edge with `stall`=1, saturates at 0xFFFF_FFFF, and is cleared by reset.
  - Undefined: `stall_cnt` is tied to 0 and no counter register exists.

## Test plan

- `D_rs`=8, `D_tuse_rs`=0, `E_dst`=8, `E_tnew`=2 (load) -> `stall_F`=`stall_D`=`flush_E`=1. Next cycle `M_dst`=8, `M_tnew`=1 -> stall=1. Following cycle `W_dst`=8 -> stall=0, `fwd_D_rs`=3.
- `D_rt`=5, `D_tuse_rt`=1, `E_dst`=5, `E_tnew`=1 -> stall=0, `fwd_D_rt`=0. Next cycle `M_dst`=5, `M_tnew`=0 -> `fwd_D_rt`=2.
- `D_rs`=0 with `E_dst`=0, `E_tnew`=2 -> stall=0, `fwd_D_rs`=0. `D_rs`=31, `E_dst`=31, `E_tnew`=0 (jal) -> `fwd_D_rs`=1, stall=0.
- `E_md_start`=1, `E_md_div`=1 at cycle t; `D_md_use`=1 held -> stall=1 for cycles t..t+10; `md_done`=1 at t+11 with stall=0. With `MULT_CYC` the window is t..t+5.
- Divide started, `reset` pulled low at t+3 between clock edges -> `md_busy`=0 and `md_done`=0 immediately. After release, no `md_done` pulse occurs.
- With `HAZARD_STALL_STAT_EN` defined: 3 load-use stalls plus one divide stall (11 cycles) -> `stall_cnt`=14. Undefined -> `stall_cnt`=0.
